// File: rtl/control_unit.sv
// Single-cycle ARM-style control unit: main/ALU decoder, PC logic and
// conditional execution against four stored condition flags {N,Z,C,V}.
module control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Rd,
    input  logic [1:0] Op,
    input  logic [1:0] sh,
    input  logic [5:0] Funct,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    output logic       MemtoReg,
    output logic       ALUSrc,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] ALUControl,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite
);

    logic       regw_dec;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       aluop;
    logic       nowrite;
    logic       pcs;
    logic       condex;
    logic [1:0] flagw;
    logic [3:0] cmd;
    logic [3:0] flags;
    logic       n, z, c, v;

    assign cmd = Funct[4:1];
    assign {n, z, c, v} = flags;

    // Main decoder
    always_comb begin
        regw_dec = 1'b0;
        memw     = 1'b0;
        MemtoReg = 1'b0;
        ALUSrc   = 1'b0;
        ImmSrc   = 2'b00;
        RegSrc   = 2'b00;
        branch   = 1'b0;
        aluop    = 1'b0;
        case (Op)
            2'b00: begin
                regw_dec = 1'b1;
                ALUSrc   = Funct[5];
                aluop    = 1'b1;
            end
            2'b01: begin
                ALUSrc = 1'b1;
                ImmSrc = 2'b01;
                if (Funct[0]) begin
                    regw_dec = 1'b1;
                    MemtoReg = 1'b1;
                end else begin
                    memw   = 1'b1;
                    RegSrc = 2'b10;
                end
            end
            2'b10: begin
                ALUSrc = 1'b1;
                ImmSrc = 2'b10;
                RegSrc = 2'b01;
                branch = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU decoder; MOV and the shifts share cmd 1101, split by I and sh
    always_comb begin
        ALUControl = 4'b0000;
        flagw      = 2'b00;
        nowrite    = 1'b0;
        if (aluop) begin
            case (cmd)
                4'b0100: ALUControl = 4'b0000;
                4'b0010: ALUControl = 4'b0001;
                4'b0000: ALUControl = 4'b0010;
                4'b1100: ALUControl = 4'b0011;
                4'b0001: ALUControl = 4'b0100;
                4'b1010: ALUControl = 4'b0001;
                4'b1101: begin
                    if (Funct[5]) begin
                        ALUControl = 4'b0101;
                    end else begin
                        case (sh)
                            2'b00:   ALUControl = 4'b0110;
                            2'b01:   ALUControl = 4'b0111;
                            2'b10:   ALUControl = 4'b1000;
                            default: ALUControl = 4'b1001;
                        endcase
                    end
                end
                default: ALUControl = 4'b0000;
            endcase
            flagw[1] = Funct[0];
            flagw[0] = Funct[0] & ((ALUControl == 4'b0000) | (ALUControl == 4'b0001));
            if (cmd == 4'b1010) begin
                flagw   = 2'b11;
                nowrite = 1'b1;
            end
        end
    end

    assign regw = regw_dec & ~nowrite;
    assign pcs  = branch | (regw & (Rd == 4'b1111));

    always_comb begin
        condex = 1'b0;
        case (Cond)
            4'b0000: condex = z;
            4'b0001: condex = ~z;
            4'b0010: condex = c;
            4'b0011: condex = ~c;
            4'b0100: condex = n;
            4'b0101: condex = ~n;
            4'b0110: condex = v;
            4'b0111: condex = ~v;
            4'b1000: condex = c & ~z;
            4'b1001: condex = ~c | z;
            4'b1010: condex = (n == v);
            4'b1011: condex = (n != v);
            4'b1100: condex = ~z & (n == v);
            4'b1101: condex = z | (n != v);
            4'b1110: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    assign PCSrc    = pcs & condex;
    assign RegWrite = regw & condex;
    assign MemWrite = memw & condex;

    // The setting instruction is evaluated with the pre-edge flags
    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= 4'b0000;
        end else begin
            if (flagw[1] & condex) flags[3:2] <= ALUFlags[3:2];
            if (flagw[0] & condex) flags[1:0] <= ALUFlags[1:0];
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: decoder vectors, conditional execution
// and flag update/reset behaviour with hand-computed expectations.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] Rd;
    logic [1:0] Op;
    logic [1:0] sh;
    logic [5:0] Funct;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic       MemtoReg;
    logic       ALUSrc;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [3:0] ALUControl;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;

    int passed = 0;
    int total  = 0;

    control_unit dut (
        .clk(clk), .rst(rst), .Rd(Rd), .Op(Op), .sh(sh), .Funct(Funct),
        .Cond(Cond), .ALUFlags(ALUFlags), .MemtoReg(MemtoReg), .ALUSrc(ALUSrc),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
        .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [1:0] op, input logic [5:0] funct,
                         input logic [3:0] cond, input logic [3:0] rd);
        Op = op; Funct = funct; Cond = cond; Rd = rd;
        #1;
    endtask

    // Non-flag-setting ADD under a condition: RegWrite exposes CondEx
    task automatic chk_cond(input string tag, input logic [3:0] cond, input logic exp);
        drive(2'b00, 6'b001000, cond, 4'b0000);
        check(tag, {15'd0, RegWrite}, {15'd0, exp});
    endtask

    task automatic edge_sync;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; Rd = 4'd0; Op = 2'b00; sh = 2'b00; Funct = 6'b001000;
        Cond = 4'b1110; ALUFlags = 4'b0000;
        edge_sync();
        chk_cond("rst_eq", 4'b0000, 1'b0);
        chk_cond("rst_al", 4'b1110, 1'b1);
        chk_cond("rst_ne", 4'b0001, 1'b1);
        chk_cond("rst_nv", 4'b1111, 1'b0);
        edge_sync();
        rst = 1'b0;
        edge_sync();

        // DP register ADD
        drive(2'b00, 6'b001000, 4'b1110, 4'b0000);
        check("dpreg_all", {MemtoReg, ALUSrc, ImmSrc, RegSrc, ALUControl, PCSrc, RegWrite, MemWrite},
              {1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0});
        // DP immediate
        drive(2'b00, 6'b101000, 4'b1110, 4'b0000);
        check("dpimm", {ALUSrc, ImmSrc, RegWrite, ALUControl}, {1'b1, 2'b00, 1'b1, 4'b0000});
        // STR
        drive(2'b01, 6'b000000, 4'b1110, 4'b0000);
        check("str", {MemtoReg, ALUSrc, ImmSrc, RegSrc, ALUControl, PCSrc, RegWrite, MemWrite},
              {1'b0, 1'b1, 2'b01, 2'b10, 4'b0000, 1'b0, 1'b0, 1'b1});
        // STR failing its condition: datapath controls still driven
        drive(2'b01, 6'b000000, 4'b0000, 4'b0000);
        check("str_eq_gated", {ALUSrc, ImmSrc, RegSrc, MemWrite}, {1'b1, 2'b01, 2'b10, 1'b0});
        // LDR
        drive(2'b01, 6'b000001, 4'b1110, 4'b0000);
        check("ldr", {MemtoReg, ALUSrc, ImmSrc, RegSrc, RegWrite, MemWrite},
              {1'b1, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0});
        // B
        drive(2'b10, 6'b100001, 4'b1110, 4'b0000);
        check("b", {ALUSrc, ImmSrc, RegSrc, PCSrc, RegWrite, MemWrite, ALUControl},
              {1'b1, 2'b10, 2'b01, 1'b1, 1'b0, 1'b0, 4'b0000});
        drive(2'b10, 6'b100001, 4'b0000, 4'b0000);
        check("b_eq_gated", {15'd0, PCSrc}, 16'd0);
        // Op=11 decodes to nothing
        drive(2'b11, 6'b111111, 4'b1110, 4'b1111);
        check("op11", {MemtoReg, ALUSrc, ImmSrc, RegSrc, ALUControl, PCSrc, RegWrite, MemWrite}, 16'd0);
        // Write to PC
        drive(2'b00, 6'b001000, 4'b1110, 4'b1111);
        check("pc_write", {PCSrc, RegWrite}, 2'b11);

        // ALU decoder table (S=0 so no flag writes)
        drive(2'b00, 6'b000100, 4'b1110, 4'b0000); check("alu_sub", ALUControl, 4'b0001);
        drive(2'b00, 6'b000000, 4'b1110, 4'b0000); check("alu_and", ALUControl, 4'b0010);
        drive(2'b00, 6'b011000, 4'b1110, 4'b0000); check("alu_orr", ALUControl, 4'b0011);
        drive(2'b00, 6'b000010, 4'b1110, 4'b0000); check("alu_eor", ALUControl, 4'b0100);
        drive(2'b00, 6'b111010, 4'b1110, 4'b0000); check("alu_mov", ALUControl, 4'b0101);
        sh = 2'b00; drive(2'b00, 6'b011010, 4'b1110, 4'b0000); check("alu_lsl", ALUControl, 4'b0110);
        sh = 2'b01; drive(2'b00, 6'b011010, 4'b1110, 4'b0000); check("alu_lsr", ALUControl, 4'b0111);
        sh = 2'b10; drive(2'b00, 6'b011010, 4'b1110, 4'b0000); check("alu_asr", ALUControl, 4'b1000);
        sh = 2'b11; drive(2'b00, 6'b011010, 4'b1110, 4'b0000); check("alu_ror", ALUControl, 4'b1001);
        sh = 2'b00;
        drive(2'b00, 6'b001110, 4'b1110, 4'b0000); check("alu_other", ALUControl, 4'b0000);

        // Conditional ADDS: EQ fails with Z=0, so flags must not load
        @(negedge clk);
        ALUFlags = 4'b0100;
        drive(2'b00, 6'b001001, 4'b0000, 4'b0000);
        check("adds_eq_rw", {15'd0, RegWrite}, 16'd0);
        edge_sync();
        check("adds_eq_z_held", {15'd0, RegWrite}, 16'd0);
        drive(2'b00, 6'b001001, 4'b1110, 4'b0000);
        check("adds_al_rw", {15'd0, RegWrite}, 16'd1);
        chk_cond("adds_al_pre_edge_eq", 4'b0000, 1'b0);
        drive(2'b00, 6'b001001, 4'b1110, 4'b0000);
        edge_sync();
        chk_cond("after_adds_eq", 4'b0000, 1'b1);
        chk_cond("after_adds_ne", 4'b0001, 1'b0);
        chk_cond("after_adds_cs", 4'b0010, 1'b0);

        // ADDS loading C,V: flags become N0 Z0 C1 V1
        @(negedge clk);
        ALUFlags = 4'b0011;
        drive(2'b00, 6'b001001, 4'b1110, 4'b0000);
        edge_sync();
        chk_cond("cv_cs", 4'b0010, 1'b1);
        chk_cond("cv_vs", 4'b0110, 1'b1);
        chk_cond("cv_eq", 4'b0000, 1'b0);
        chk_cond("cv_hi", 4'b1000, 1'b1);
        chk_cond("cv_ge", 4'b1010, 1'b0);
        chk_cond("cv_lt", 4'b1011, 1'b1);

        // ANDS writes only N,Z: flags become N1 Z1 C1 V1
        @(negedge clk);
        ALUFlags = 4'b1100;
        drive(2'b00, 6'b000001, 4'b1110, 4'b0000);
        edge_sync();
        chk_cond("ands_mi", 4'b0100, 1'b1);
        chk_cond("ands_eq", 4'b0000, 1'b1);
        chk_cond("ands_cs_held", 4'b0010, 1'b1);
        chk_cond("ands_vs_held", 4'b0110, 1'b1);
        chk_cond("ands_ls", 4'b1001, 1'b1);
        chk_cond("ands_gt", 4'b1100, 1'b0);
        chk_cond("ands_le", 4'b1101, 1'b1);

        // CMP: flags become N1 Z0 C0 V1, no register write
        @(negedge clk);
        ALUFlags = 4'b1001;
        drive(2'b00, 6'b010101, 4'b1110, 4'b0000);
        check("cmp_rw_alu", {11'd0, RegWrite, ALUControl}, {11'd0, 1'b0, 4'b0001});
        edge_sync();
        chk_cond("cmp_mi", 4'b0100, 1'b1);
        chk_cond("cmp_vs", 4'b0110, 1'b1);
        chk_cond("cmp_ne", 4'b0001, 1'b1);
        chk_cond("cmp_cs", 4'b0010, 1'b0);
        chk_cond("cmp_ge", 4'b1010, 1'b1);

        // Reset wins over the CMP flag write in the same cycle
        @(negedge clk);
        rst = 1'b1;
        drive(2'b00, 6'b010101, 4'b1110, 4'b0000);
        edge_sync();
        chk_cond("rstpri_mi", 4'b0100, 1'b0);
        chk_cond("rstpri_vs", 4'b0110, 1'b0);
        chk_cond("rstpri_eq", 4'b0000, 1'b0);
        chk_cond("rstpri_pl", 4'b0101, 1'b1);
        rst = 1'b0;
        edge_sync();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish, required finish before 50000");
        $fatal(1, "timeout");
    end

endmodule
